// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction width, opcode field position,
// opcode values and the fetch FSM state encoding.
package cpu_pkg;
   localparam int INSTR_WIDTH = 49;
   localparam int OPC_MSB     = 48;
   localparam int OPC_LSB     = 44;

   localparam logic [4:0] OPC_LD  = 5'h01;
   localparam logic [4:0] OPC_ST  = 5'h02;
   localparam logic [4:0] OPC_HLT = 5'h1F;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HALT  = 2'd2
   } fetch_state_e;
endpackage

// File: rtl/fetch_pc.sv
// Program counter register.
//   clk, rst_n   : clock, async active-low reset (pc -> 0)
//   inc_i        : advance pc by one, wrapping at 2^ADDR_W
//   load_i       : load load_pc_i (takes priority over inc_i)
//   load_pc_i    : redirect target
//   pc_o         : current pc
module fetch_pc #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              inc_i,
   input  logic              load_i,
   input  logic [ADDR_W-1:0] load_pc_i,
   output logic [ADDR_W-1:0] pc_o
);
   logic [ADDR_W-1:0] pc_q, pc_d;

   always_comb begin
      pc_d = pc_q;
      if (load_i)     pc_d = load_pc_i;
      else if (inc_i) pc_d = pc_q + ADDR_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pc_q <= '0;
      else        pc_q <= pc_d;
   end

   assign pc_o = pc_q;
endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: requests words from instruction memory at pc,
// holds one fetched word in an output register for the decoder, and
// supports stall, redirect (flush + refetch) and halt on HLT.
//   imem_req/imem_addr/imem_rdata/imem_valid : instruction memory port
//   stall                : decoder not accepting this cycle
//   redirect/redirect_pc : flush and refetch from redirect_pc
//   instr/instr_valid/instr_pc : registered instruction to decoder
//   halted               : HLT fetched, fetching stopped
//   instr_count          : saturating count of consumed instructions
module instr_fetch
   import cpu_pkg::*;
#(
   parameter int ADDR_W  = 8,
   parameter int INSTR_W = INSTR_WIDTH
) (
   input  logic               clk,
   input  logic               rst_n,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               imem_valid,
   input  logic               stall,
   input  logic               redirect,
   input  logic [ADDR_W-1:0]  redirect_pc,
   output logic [INSTR_W-1:0] instr,
   output logic               instr_valid,
   output logic [ADDR_W-1:0]  instr_pc,
   output logic               halted,
   output logic [15:0]        instr_count
);
   fetch_state_e       state_q, state_d;
   logic [ADDR_W-1:0]  pc;
   logic [INSTR_W-1:0] instr_q, instr_d;
   logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;
   logic               instr_valid_q, instr_valid_d;
   logic [15:0]        count_q, count_d;
   logic               load, consume;

   // Only request when the output register is free or being drained.
   assign imem_req = (state_q == FETCH) && (!instr_valid_q || !stall);
   // Redirect squashes any word returned in the same cycle.
   assign load     = imem_req && imem_valid && !redirect;
   assign consume  = instr_valid_q && !stall && !redirect;

   fetch_pc #(.ADDR_W(ADDR_W)) u_pc (
      .clk       (clk),
      .rst_n     (rst_n),
      .inc_i     (load),
      .load_i    (redirect),
      .load_pc_i (redirect_pc),
      .pc_o      (pc)
   );

   always_comb begin
      state_d       = state_q;
      instr_d       = instr_q;
      instr_pc_d    = instr_pc_q;
      instr_valid_d = instr_valid_q;
      count_d       = count_q;

      case (state_q)
         IDLE:    state_d = FETCH;
         FETCH:   if (load && imem_rdata[OPC_MSB:OPC_LSB] == OPC_HLT) state_d = HALT;
         HALT:    state_d = HALT;
         default: state_d = IDLE;
      endcase

      if (consume) begin
         instr_valid_d = 1'b0;
         if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
      end
      if (load) begin
         instr_d       = imem_rdata;
         instr_pc_d    = pc;
         instr_valid_d = 1'b1;
      end

      if (redirect) begin
         state_d       = FETCH;
         instr_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         instr_q       <= '0;
         instr_pc_q    <= '0;
         instr_valid_q <= 1'b0;
         count_q       <= '0;
      end else begin
         state_q       <= state_d;
         instr_q       <= instr_d;
         instr_pc_q    <= instr_pc_d;
         instr_valid_q <= instr_valid_d;
         count_q       <= count_d;
      end
   end

   assign imem_addr   = pc;
   assign instr       = instr_q;
   assign instr_pc    = instr_pc_q;
   assign instr_valid = instr_valid_q;
   assign halted      = (state_q == HALT);
   assign instr_count = count_q;
endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req;
   logic [7:0]  imem_addr;
   logic [48:0] imem_rdata;
   logic        imem_valid;
   logic        stall;
   logic        redirect;
   logic [7:0]  redirect_pc;
   logic [48:0] instr;
   logic        instr_valid;
   logic [7:0]  instr_pc;
   logic        halted;
   logic [15:0] instr_count;

   // memory model: word N at address N, optional HLT opcode at hlt_addr
   logic        mem_en;
   logic        hlt_en;
   logic [7:0]  hlt_addr;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   always_comb begin
      imem_rdata = {5'h00, 36'd0, imem_addr};
      if (hlt_en && imem_addr == hlt_addr) imem_rdata[48:44] = 5'h1F;
   end
   // valid deliberately not gated by imem_req so ignoring it is exercised
   assign imem_valid = mem_en;

   instr_fetch #(.ADDR_W(8), .INSTR_W(49)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_rdata  (imem_rdata),
      .imem_valid  (imem_valid),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .instr       (instr),
      .instr_valid (instr_valid),
      .instr_pc    (instr_pc),
      .halted      (halted),
      .instr_count (instr_count)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 8'h00;
      mem_en = 1'b1; hlt_en = 1'b0; hlt_addr = 8'h00;
      #2;
      // reset state
      chk("rst_req",   imem_req, 0);
      chk("rst_valid", instr_valid, 0);
      chk("rst_instr", instr, 0);
      chk("rst_count", instr_count, 0);
      chk("rst_halt",  halted, 0);
      do_reset();

      // streaming fetch, 0-cycle memory
      step();                               // IDLE -> FETCH
      chk("s_req",  imem_req, 1);
      chk("s_addr", imem_addr, 8'h00);
      for (int i = 0; i < 6; i++) begin
         step();
         chk("s_pc",    instr_pc, i);
         chk("s_vld",   instr_valid, 1);
         chk("s_count", instr_count, i);
      end
      chk("s_instr5", instr, 49'd5);

      // stall holds the output register, no request, no pc advance
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("st_pc",    instr_pc, 8'h05);
         chk("st_req",   imem_req, 0);
         chk("st_addr",  imem_addr, 8'h06);
         chk("st_count", instr_count, 5);
      end
      stall = 1'b0;
      step();
      chk("st_rel_pc",    instr_pc, 8'h06);
      chk("st_rel_instr", instr, 49'd6);
      chk("st_rel_count", instr_count, 6);

      // redirect coincident with valid word for addr 7
      chk("rd_addr7", imem_addr, 8'h07);
      redirect = 1'b1; redirect_pc = 8'h40;
      step();
      redirect = 1'b0;
      chk("rd_vld",   instr_valid, 0);
      chk("rd_addr",  imem_addr, 8'h40);
      chk("rd_count", instr_count, 6);
      step();
      chk("rd_pc40", instr_pc, 8'h40);
      chk("rd_vld2", instr_valid, 1);

      // HLT at address 3
      hlt_en = 1'b1; hlt_addr = 8'h03;
      do_reset();
      chk("h_rstcnt", instr_count, 0);
      step();
      for (int i = 0; i < 4; i++) step();
      chk("h_pc",    instr_pc, 8'h03);
      chk("h_opc",   instr[48:44], 5'h1F);
      chk("h_halt",  halted, 1);
      chk("h_req",   imem_req, 0);
      step();
      chk("h_halt2", halted, 1);
      chk("h_req2",  imem_req, 0);
      chk("h_vld2",  instr_valid, 0);
      chk("h_cnt2",  instr_count, 4);
      redirect = 1'b1; redirect_pc = 8'h10;
      step();
      redirect = 1'b0; hlt_en = 1'b0;
      chk("h_unhalt", halted, 0);
      chk("h_addr",   imem_addr, 8'h10);
      chk("h_req3",   imem_req, 1);
      step();
      chk("h_pc10",   instr_pc, 8'h10);

      // pc wrap at 0xFF
      redirect = 1'b1; redirect_pc = 8'hFF;
      step();
      redirect = 1'b0;
      chk("w_addrff", imem_addr, 8'hFF);
      step();
      chk("w_pcff", instr_pc, 8'hFF);
      chk("w_wrap", imem_addr, 8'h00);
      // outstanding request with no data, then reset mid-wait
      mem_en = 1'b0;
      step();
      chk("w_wait_req", imem_req, 1);
      chk("w_wait_vld", instr_valid, 0);
      rst_n = 1'b0;
      #1;
      chk("mr_req",   imem_req, 0);
      chk("mr_addr",  imem_addr, 0);
      chk("mr_instr", instr, 0);
      chk("mr_ipc",   instr_pc, 0);
      chk("mr_count", instr_count, 0);
      chk("mr_halt",  halted, 0);
      step();
      rst_n = 1'b1; mem_en = 1'b1;
      step();
      chk("mr_req2",  imem_req, 1);
      chk("mr_addr2", imem_addr, 8'h00);
      step();
      chk("mr_pc0",   instr_pc, 8'h00);
      chk("mr_vld",   instr_valid, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got=running exp=finished");
      $fatal(1, "timeout");
   end
endmodule
